coin_acceptor: RTL and testbench

Front-end stage that turns the vending machine's two raw mechanical coin sensors into the clean 2-bit `coin` code consumed by the `vend` FSM. It synchronizes and debounces both sensors, qualifies one coin per insertion, and emits exactly one single-cycle code per coin. A mandatory idle gap guarantees `vend` always sees `coin == 0` between consecutive coins.

---
 rtl/vend_pkg.sv | 31 +++
 rtl/coin_acceptor_sync2.sv | 21 ++
 rtl/coin_acceptor.sv | 158 +++++++++++++++
 tb/tb_coin_acceptor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared coin codes and acceptor state type for the vending front end and vend FSM.
package vend_pkg;

  localparam logic [1:0] COIN_NONE   = 2'd0;
  localparam logic [1:0] COIN_NICKEL = 2'd1;
  localparam logic [1:0] COIN_DIME   = 2'd2;
  localparam logic [1:0] COIN_BAD    = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    QUAL,
    EMIT,
    RELEASE,
    GAP
  } acceptor_state_t;

  // Sensor pattern {dime, nickel} to coin code; a dual-sensor hit maps to
  // COIN_BAD only when the caller treats it as a reject.
  function automatic logic [1:0] pattern_code(input logic [1:0] pat, input logic reject_both);
    logic [1:0] code;
    code = COIN_NONE;
    case (pat)
      2'b01:   code = COIN_NICKEL;
      2'b10:   code = COIN_DIME;
      2'b11:   code = reject_both ? COIN_BAD : COIN_DIME;
      default: code = COIN_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/coin_acceptor_sync2.sv
// Single-bit two-flop synchronizer with synchronous active-high reset.
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronize, debounce, qualify and emit one code per coin.
// Optional COIN_REJECT_EN: a qualified dual-sensor hit pulses coin_reject instead of a dime.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       nickel_sense,
  input  logic       dime_sense,
  output logic [1:0] coin,
  output logic       coin_reject,
  output logic       busy
);

  localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > GAP_CYCLES) ? DEBOUNCE_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] GAP_C = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic            s_n;
  logic            s_d;
  logic [1:0]      pat;
  acceptor_state_t state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [1:0]      cap, cap_d;
  logic [1:0]      coin_q, coin_d;
  logic [1:0]      emit_code;

  sync2 u_sync_nickel (
    .clock (clock),
    .reset (reset),
    .d     (nickel_sense),
    .q     (s_n)
  );

  sync2 u_sync_dime (
    .clock (clock),
    .reset (reset),
    .d     (dime_sense),
    .q     (s_d)
  );

  assign pat = {s_d, s_n};

`ifdef COIN_REJECT_EN
  logic rej_q, rej_d;
  logic emit_rej;

  always_comb begin
    emit_code = pattern_code(cap, 1'b1);
    emit_rej  = (emit_code == COIN_BAD);
    if (emit_rej) begin
      emit_code = COIN_NONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rej_q <= 1'b0;
    end else begin
      rej_q <= rej_d;
    end
  end

  assign coin_reject = rej_q;
`else
  always_comb begin
    emit_code = pattern_code(cap, 1'b0);
  end

  assign coin_reject = 1'b0;
`endif

  // The output register defaults to none every cycle, so a loaded code
  // lives only for the single EMIT cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cap_d   = cap;
    coin_d  = COIN_NONE;
`ifdef COIN_REJECT_EN
    rej_d   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pat != 2'b00) begin
          cap_d   = pat;
          cnt_d   = ONE_C;
          state_d = QUAL;
        end
      end
      QUAL: begin
        if (pat == 2'b00) begin
          state_d = IDLE;
        end else if (pat != cap) begin
          cap_d = pat;
          cnt_d = ONE_C;
        end else if (cnt == DEB_C) begin
          state_d = EMIT;
          coin_d  = emit_code;
`ifdef COIN_REJECT_EN
          rej_d   = emit_rej;
`endif
        end else begin
          cnt_d = cnt + ONE_C;
        end
      end
      EMIT: begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
      RELEASE: begin
        if (pat != 2'b00) begin
          cnt_d = '0;
        end else if (cnt == DEB_C) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + ONE_C;
        end
      end
      GAP: begin
        if (cnt == GAP_C) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + ONE_C;
        end
      end
      default: begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
    endcase
  end

  // Resetting into RELEASE keeps a sensor held across reset from emitting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= RELEASE;
      cnt    <= '0;
      cap    <= 2'b00;
      coin_q <= COIN_NONE;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      cap    <= cap_d;
      coin_q <= coin_d;
    end
  end

  assign coin = coin_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: run-length reference model plus directed scenarios.
module tb_coin_acceptor;

  localparam int D = 4;
  localparam int G = 2;
  localparam int MIN_SPACING = 2 * D + G + 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       nickel_sense = 1'b0;
  logic       dime_sense = 1'b0;
  logic [1:0] coin;
  logic       coin_reject;
  logic       busy;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (D),
    .GAP_CYCLES      (G)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .nickel_sense (nickel_sense),
    .dime_sense   (dime_sense),
    .coin         (coin),
    .coin_reject  (coin_reject),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  int edgecnt = 0;
  always @(posedge clock) edgecnt++;

  // Reference model: the press is judged on sensor values delayed by two
  // samples; a coin is emitted once one non-zero pattern has persisted for
  // D+1 consecutive samples, then the block stays busy for one cycle, until
  // D+1 consecutive quiet samples are seen, and for G+1 further cycles.
  localparam int PH_HUNT = 0, PH_EMITTED = 1, PH_QUIET = 2, PH_GAP = 3;
  logic [1:0] m_s1 = 2'b00, m_s2 = 2'b00, m_s, m_last = 2'b00;
  int   phase = PH_QUIET, run = 0, quiet = 0, gap_n = 0;
  int   exp_coin = 0, exp_rej = 0, exp_busy = 1;
  bit   model_valid = 0;

  always @(posedge clock) begin
    m_s  = m_s2;
    m_s2 = m_s1;
    m_s1 = {dime_sense, nickel_sense};
    exp_coin = 0;
    exp_rej  = 0;
    if (reset) begin
      m_s1 = 2'b00; m_s2 = 2'b00;
      phase = PH_QUIET; quiet = 0; exp_busy = 1; model_valid = 1;
    end else if (model_valid) begin
      case (phase)
        PH_HUNT: begin
          if (m_s == 2'b00) begin
            run = 0; exp_busy = 0;
          end else begin
            if (run > 0 && m_s == m_last) run++;
            else begin run = 1; m_last = m_s; end
            exp_busy = 1;
            if (run == D + 1) begin
              phase = PH_EMITTED;
              if (m_s == 2'b01) exp_coin = 1;
              else if (m_s == 2'b10) exp_coin = 2;
              else begin
`ifdef COIN_REJECT_EN
                exp_rej = 1;
`else
                exp_coin = 2;
`endif
              end
            end
          end
        end
        PH_EMITTED: begin
          phase = PH_QUIET; quiet = 0; exp_busy = 1;
        end
        PH_QUIET: begin
          quiet = (m_s == 2'b00) ? quiet + 1 : 0;
          if (quiet == D + 1) begin phase = PH_GAP; gap_n = 0; end
          exp_busy = 1;
        end
        default: begin
          gap_n++;
          if (gap_n == G + 1) begin phase = PH_HUNT; run = 0; exp_busy = 0; end
          else exp_busy = 1;
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      check("coin", int'(coin), exp_coin);
      check("coin_reject", int'(coin_reject), exp_rej);
      check("busy", int'(busy), exp_busy);
    end
  end

  int n_nick = 0, n_dime = 0, n_rej = 0, last_edge = -1;
  int prev_emit = -1, min_spacing = 1000000;
  always @(negedge clock) begin
    if (reset) prev_emit = -1;
    else if (model_valid && (coin != 2'd0 || coin_reject)) begin
      if (coin == 2'd1) n_nick++;
      if (coin == 2'd2) n_dime++;
      if (coin_reject) n_rej++;
      last_edge = edgecnt;
      if (prev_emit >= 0 && edgecnt - prev_emit < min_spacing) min_spacing = edgecnt - prev_emit;
      prev_emit = edgecnt;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic clear_counts();
    n_nick = 0; n_dime = 0; n_rej = 0; last_edge = -1;
  endtask

  task automatic press(input logic n, input logic d, input int len);
    nickel_sense = n; dime_sense = d;
    tick(len);
    nickel_sense = 1'b0; dime_sense = 1'b0;
  endtask

  int start;
  logic bounce [5];

  initial begin
    tick(2);
    check("reset_coin", int'(coin), 0);
    check("reset_reject", int'(coin_reject), 0);
    check("reset_busy", int'(busy), 1);
    reset = 1'b0;
    tick(20);
    check("idle_after_reset_busy", int'(busy), 0);

    clear_counts();
    start = edgecnt + 1;
    press(1'b1, 1'b0, 10);
    tick(20);
    check("nickel_pulses", n_nick, 1);
    check("nickel_latency", last_edge - start, 6);
    check("nickel_busy_low", int'(busy), 0);

    clear_counts();
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    foreach (bounce[i]) begin dime_sense = bounce[i]; tick(1); end
    start = edgecnt + 1;
    press(1'b0, 1'b1, 8);
    tick(20);
    check("bounce_dime_pulses", n_dime, 1);
    check("bounce_latency", last_edge - start, 6);

    clear_counts();
    press(1'b1, 1'b0, 3);
    tick(20);
    check("glitch3_pulses", n_nick, 0);
    check("glitch3_busy_low", int'(busy), 0);
    press(1'b1, 1'b0, D);
    tick(20);
    check("press_D_pulses", n_nick, 0);
    press(1'b1, 1'b0, D + 1);
    tick(20);
    check("press_D1_pulses", n_nick, 1);

    clear_counts();
    press(1'b1, 1'b1, 8);
    tick(20);
    check("both_nickel", n_nick, 0);
`ifdef COIN_REJECT_EN
    check("both_reject", n_rej, 1);
    check("both_dime", n_dime, 0);
`else
    check("both_reject", n_rej, 0);
    check("both_dime", n_dime, 1);
`endif

    // The dime's synchronized samples fall entirely inside the release window.
    clear_counts();
    start = edgecnt + 1;
    press(1'b1, 1'b0, 8);
    tick(1);
    press(1'b0, 1'b1, 8);
    tick(25);
    check("b2b_nickel", n_nick, 1);
    check("b2b_nickel_latency", last_edge - start, 6);
    check("b2b_dime_dropped", n_dime, 0);

    clear_counts();
    nickel_sense = 1'b1;
    tick(6);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("reset_wins_coin", int'(coin), 0);
    tick(4);
    nickel_sense = 1'b0;
    tick(20);
    check("reset_wins_pulses", n_nick, 0);

    clear_counts();
    dime_sense = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    dime_sense = 1'b0;
    tick(20);
    check("held_reset_dime", n_dime, 0);
    press(1'b0, 1'b1, 8);
    tick(20);
    check("after_reset_dime", n_dime, 1);

    repeat (300) begin
      int r, len;
      r   = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1; tick(1); reset = 1'b0;
      end
      if (r <= 3) press(1'b0, 1'b0, len);
      else if (r <= 5) press(1'b1, 1'b0, len);
      else if (r <= 7) press(1'b0, 1'b1, len);
      else if (r == 8) press(1'b1, 1'b1, len);
      else begin
        repeat (len) begin
          nickel_sense = 1'($urandom_range(0, 1));
          dime_sense   = 1'($urandom_range(0, 1));
          tick(1);
        end
        nickel_sense = 1'b0; dime_sense = 1'b0;
      end
    end
    tick(25);
    check("random_min_spacing_ok", int'(min_spacing >= MIN_SPACING), 1);
    check("random_end_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
